// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the multi-precision adder controller: FSM encoding, the
// shared adder word width, and an index-width helper.
package adder_ctrl_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to index n words; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Shared WORD_W-bit ripple-carry adder with carry-out and two's-complement overflow.
module ripple_carry_adder
  import adder_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              Cin,
  output logic [WORD_W-1:0] Sum,
  output logic              Cout,
  output logic              Overflow
);

  logic [WORD_W:0] carry;

  always_comb begin
    carry[0] = Cin;
    for (int i = 0; i < WORD_W; i++) begin
      Sum[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout     = carry[WORD_W];
  // Carry into the sign bit differs from carry out of it exactly on signed overflow.
  assign Overflow = carry[WORD_W] ^ carry[WORD_W - 1];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision adder: one 32-bit word per cycle through a shared adder, LSW first.
// Optional subtract mode when SUB_MODE_EN is defined (adds the op_sub port).
module wide_add_sequencer
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NWORDS*WORD_W-1:0] a_in,
  input  logic [NWORDS*WORD_W-1:0] b_in,
  input  logic                     cin,
`ifdef SUB_MODE_EN
  input  logic                     op_sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [NWORDS*WORD_W-1:0] sum_out,
  output logic                     cout,
  output logic                     overflow
);

  localparam int unsigned TotalW = NWORDS * WORD_W;
  localparam int unsigned IdxW   = clog2(NWORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [TotalW-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              busy_q, busy_d, done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;
`ifdef SUB_MODE_EN
  logic              sub_q, sub_d;
`endif

  logic [WORD_W-1:0] add_a, add_b, add_sum;
  logic              add_cout, add_ovf;

  always_comb begin
    add_a = a_q[idx_q * WORD_W +: WORD_W];
`ifdef SUB_MODE_EN
    add_b = b_q[idx_q * WORD_W +: WORD_W] ^ {WORD_W{sub_q}};
`else
    add_b = b_q[idx_q * WORD_W +: WORD_W];
`endif
  end

  ripple_carry_adder u_adder (
    .A        (add_a),
    .B        (add_b),
    .Cin      (carry_q),
    .Sum      (add_sum),
    .Cout     (add_cout),
    .Overflow (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SUB_MODE_EN
    sub_d   = sub_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = '0;
`ifdef SUB_MODE_EN
          sub_d   = op_sub;
          carry_d = op_sub | cin;
`else
          carry_d = cin;
`endif
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q * WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          cout_d  = add_cout;
          ovf_d   = add_ovf;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SUB_MODE_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef SUB_MODE_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_out  = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
